// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifq_pkg;

    localparam int IFQ_DEFAULT_DEPTH = 4;
    localparam int INSTR_BYTES       = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FULL
    } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch FIFO storage with a registered head entry, so the consumer never
// sees a combinational path from the write side.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  ifq_entry_t             push_data,
    output ifq_entry_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    ifq_entry_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_next;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign rd_next = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is reloaded from the next slot on a pop, or straight from the
    // write data when the queue is (or is about to become) empty.
    // A flush leaves it untouched so deq outputs hold while invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (do_pop && count > CW'(1)) begin
                head <= mem[rd_next];
            end else if (do_push && (empty || (do_pop && count == CW'(1)))) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch-side prefetch queue: owns the fetch PC, fills a FIFO from imem and
// flushes on redirect. Define IFQ_PERF_EN to add flush/starve counters.
module instr_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = IFQ_DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e    state;
    ifq_state_e    state_next;
    logic [31:0]   fetch_pc;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    ifq_entry_t    head;
    ifq_entry_t    push_data;

    assign imem_addr = fetch_pc;
    assign push_data = {fetch_pc, imem_rdata};
    assign deq_valid = ~empty & ~redirect_valid;
    assign pop       = deq_valid & deq_ready;
    assign push      = (state == S_RUN) & ~redirect_valid & (~full | pop);
    assign deq_pc    = head.pc;
    assign deq_instr = head.instr;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // S_BOOT gives imem one cycle to settle; S_FULL blocks fetch until space frees.
    always_comb begin
        state_next = state;
        unique case (state)
            S_BOOT: state_next = S_RUN;
            S_RUN: begin
                if (push && !pop && count == CW'(DEPTH - 1)) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect_valid || pop) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
            end
        end
    end

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_flush_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (deq_ready && !deq_valid) begin
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue; perf checks only when IFQ_PERF_EN is defined.
module tb_instr_prefetch_queue;
    import ifq_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_starve_cnt;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_instr      (deq_instr)
`ifdef IFQ_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: combinational, word derived from its address.
    assign imem_rdata = imem_addr ^ XOR_KEY;

    task automatic fill_expected(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + 32'(i * 4));
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        $display("[TB] test_reset");
        reset = 1'b1; deq_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (deq_valid !== 1'b0 || deq_pc !== 32'h0 || deq_instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: valid=%b pc=%h instr=%h, want 0/0/0", deq_valid, deq_pc, deq_instr);
        end
        total++;
        if (imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL reset_addr: got %h want %h", imem_addr, RESET_PC);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL boot_valid cycle %0d: got %b want 0", c, deq_valid);
            end
            @(negedge clk);
        end
        fill_expected(RESET_PC, 8);
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stream_valid cycle %0d: got %b want 1", c, deq_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                if (deq_pc !== exp_pc || deq_instr !== (exp_pc ^ XOR_KEY)) begin
                    bad++;
                    $display("[TB] FAIL stream_data: got pc=%h instr=%h want pc=%h instr=%h",
                             deq_pc, deq_instr, exp_pc, exp_pc ^ XOR_KEY);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        $display("[TB] test_stall");
        reset = 1'b1; deq_ready = 1'b0; redirect_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        total++;
        if (dut.u_fifo.count !== 3'd4 || dut.state !== S_FULL) begin
            bad++;
            $display("[TB] FAIL stall_full: count=%0d state=%0d want 4/S_FULL", dut.u_fifo.count, dut.state);
        end
        total++;
        if (imem_addr !== 32'h10 || deq_valid !== 1'b1 || deq_pc !== 32'h0) begin
            bad++;
            $display("[TB] FAIL stall_hold: addr=%h valid=%b pc=%h want 10/1/0", imem_addr, deq_valid, deq_pc);
        end
        @(negedge clk);
        #1;
        total++;
        if (imem_addr !== 32'h10) begin
            bad++;
            $display("[TB] FAIL stall_addr_hold: got %h want 00000010", imem_addr);
        end
        @(negedge clk);
        deq_ready = 1'b1;
        fill_expected(32'h0, 8);
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL drain_valid cycle %0d: got %b want 1", c, deq_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                if (deq_pc !== exp_pc || deq_instr !== (exp_pc ^ XOR_KEY)) begin
                    bad++;
                    $display("[TB] FAIL drain_data: got pc=%h instr=%h want pc=%h", deq_pc, deq_instr, exp_pc);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] exp_pc;
        $display("[TB] test_redirect_full");
        deq_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (dut.u_fifo.count !== 3'd4) begin
            bad++;
            $display("[TB] FAIL refill_count: got %0d want 4", dut.u_fifo.count);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h203; deq_ready = 1'b1;
        exp_q.delete();
        #1;
        total++;
        if (deq_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL redirect_valid_low: got %b want 0", deq_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_addr !== 32'h200 || deq_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL redirect_target: addr=%h valid=%b want 00000200/0", imem_addr, deq_valid);
        end
        @(negedge clk);
        fill_expected(32'h200, 6);
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL redir_valid cycle %0d: got %b want 1", c, deq_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                if (deq_pc !== exp_pc || deq_instr !== (exp_pc ^ XOR_KEY)) begin
                    bad++;
                    $display("[TB] FAIL redir_data: got pc=%h instr=%h want pc=%h", deq_pc, deq_instr, exp_pc);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        $display("[TB] test_wrap");
        deq_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        exp_q.delete();
        @(negedge clk);
        redirect_pc = 32'hFFFF_FFF9;
        #1;
        total++;
        if (deq_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_valid_low: got %b want 0", deq_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_addr !== 32'hFFFF_FFF8) begin
            bad++;
            $display("[TB] FAIL b2b_last_wins: got %h want fffffff8", imem_addr);
        end
        @(negedge clk);
        fill_expected(32'hFFFF_FFF8, 4);
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL wrap_valid cycle %0d: got %b want 1", c, deq_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                if (deq_pc !== exp_pc || deq_instr !== (exp_pc ^ XOR_KEY)) begin
                    bad++;
                    $display("[TB] FAIL wrap_data: got pc=%h instr=%h want pc=%h", deq_pc, deq_instr, exp_pc);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp_pc;
        $display("[TB] test_reset_midstream");
        deq_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (dut.u_fifo.count !== 3'd3 || deq_valid !== 1'b1 || deq_pc !== 32'h100) begin
            bad++;
            $display("[TB] FAIL mid_prefill: count=%0d valid=%b pc=%h want 3/1/00000100",
                     dut.u_fifo.count, deq_valid, deq_pc);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (deq_valid !== 1'b0 || deq_pc !== 32'h0 || deq_instr !== 32'h0 || imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL async_reset: valid=%b pc=%h instr=%h addr=%h want 0/0/0/%h",
                     deq_valid, deq_pc, deq_instr, imem_addr, RESET_PC);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        deq_ready = 1'b1;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL restart_boot cycle %0d: got %b want 0", c, deq_valid);
            end
            @(negedge clk);
        end
        fill_expected(RESET_PC, 4);
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (deq_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL restart_valid cycle %0d: got %b want 1", c, deq_valid);
            end else begin
                exp_pc = exp_q.pop_front();
                if (deq_pc !== exp_pc || deq_instr !== (exp_pc ^ XOR_KEY)) begin
                    bad++;
                    $display("[TB] FAIL restart_data: got pc=%h instr=%h want pc=%h", deq_pc, deq_instr, exp_pc);
                end
            end
            @(negedge clk);
        end
    endtask

`ifdef IFQ_PERF_EN
    task automatic test_perf();
        $display("[TB] test_perf");
        reset = 1'b1; deq_ready = 1'b1; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (perf_flush_cnt !== 32'd0 || perf_starve_cnt !== 32'd0) begin
            bad++;
            $display("[TB] FAIL perf_reset: flush=%0d starve=%0d want 0/0", perf_flush_cnt, perf_starve_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        deq_ready = 1'b0;
        #1;
        total++;
        if (perf_starve_cnt !== 32'd2) begin
            bad++;
            $display("[TB] FAIL perf_boot_starve: got %0d want 2", perf_starve_cnt);
        end
        for (int r = 0; r < 3; r++) begin
            redirect_valid = 1'b1; redirect_pc = 32'h300 + 32'(r * 16); deq_ready = 1'b0;
            @(negedge clk);
            redirect_valid = 1'b0; deq_ready = 1'b1;
            @(negedge clk);
            deq_ready = 1'b0;
            @(negedge clk);
        end
        #1;
        total++;
        if (perf_flush_cnt !== 32'd3 || perf_starve_cnt !== 32'd5) begin
            bad++;
            $display("[TB] FAIL perf_counts: flush=%0d starve=%0d want 3/5", perf_flush_cnt, perf_starve_cnt);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_reset_midstream();
`ifdef IFQ_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
